ptp_b: RTL and testbench

//  Word-to-byte serialiser on the Manchester Baby RAM data output side.
//  - Accepts a 32-bit word over a valid/ready handshake.
//  - Drives it MSB-first as four bytes on an 8-bit bus, each qualified by a strobe pulse.
//  - Ends with a fifth commit strobe, so a byte-collecting receiver on the same 8-bit link latches the full word.

---
 rtl/ptp_pkg.sv | 25 ++
 rtl/ptp_phase_timer.sv | 26 ++
 rtl/ptp_b.sv | 133 +++++++++++++
 tb/tb_ptp_b.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared widths, FSM state type and parameter helpers for the ptp word-to-byte link.
package ptp_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    GAP
  } ptp_tx_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ptp_phase_timer.sv
// Loadable saturating down-counter; tc_o is high while the count sits at zero.
module ptp_phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tc_o = (r_cnt == '0);

endmodule

// File: rtl/ptp_b.sv
// Word-to-byte serialiser: one 32-bit word out as MSB-first strobed bytes,
// optionally followed by a commit strobe carrying 8'h00.
module ptp_b
  import ptp_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned HIGH_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter bit          COMMIT_EN    = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              load_i,
  output logic              ready_o,
  output logic [BYTE_W-1:0] byte_o,
  output logic              strobe_o,
  output logic              done_o
);

  localparam int unsigned MAX_CYC = max3(SETUP_CYCLES, HIGH_CYCLES, GAP_CYCLES);
  localparam int unsigned PHASE_W = $clog2(MAX_CYC) + 1;
  localparam int unsigned N_BYTES = BYTES_PER_WORD + (COMMIT_EN ? 1 : 0);
  localparam int unsigned BCNT_W  = 3;

  localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HIGH_LD   = PHASE_W'(HIGH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LD    = PHASE_W'(GAP_CYCLES - 1);
  localparam logic [BCNT_W-1:0]  LAST_BYTE = BCNT_W'(N_BYTES - 1);

  if (SETUP_CYCLES == 0 || HIGH_CYCLES == 0 || GAP_CYCLES == 0) begin : g_bad_param
    $fatal(1, "ptp_b: SETUP_CYCLES, HIGH_CYCLES and GAP_CYCLES must all be >= 1");
  end

  ptp_tx_state_t       r_state;
  logic [WORD_W-1:0]   r_shift;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic                w_tmr_load;
  logic [PHASE_W-1:0]  w_tmr_val;
  logic                w_tmr_tc;

  assign ready_o = (r_state == IDLE);

  // Timer reload coincides with every state entry, so each phase lasts exactly its *_CYCLES.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = SETUP_LD;
    case (r_state)
      IDLE: begin
        w_tmr_load = load_i;
        w_tmr_val  = SETUP_LD;
      end
      SETUP: begin
        w_tmr_load = w_tmr_tc;
        w_tmr_val  = HIGH_LD;
      end
      HIGH: begin
        w_tmr_load = w_tmr_tc;
        w_tmr_val  = GAP_LD;
      end
      GAP: begin
        w_tmr_load = w_tmr_tc && (r_byte_cnt != LAST_BYTE);
        w_tmr_val  = SETUP_LD;
      end
      default: begin
        w_tmr_load = 1'b0;
        w_tmr_val  = SETUP_LD;
      end
    endcase
  end

  ptp_phase_timer #(
    .CNT_W(PHASE_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .tc_o       (w_tmr_tc)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      byte_o     <= '0;
      strobe_o   <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_i) begin
            r_shift    <= word_i;
            r_byte_cnt <= '0;
            byte_o     <= word_i[WORD_W-1 -: BYTE_W];
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          if (w_tmr_tc) begin
            strobe_o <= 1'b1;
            r_state  <= HIGH;
          end
        end
        HIGH: begin
          if (w_tmr_tc) begin
            strobe_o <= 1'b0;
            r_state  <= GAP;
          end
        end
        GAP: begin
          if (w_tmr_tc) begin
            if (r_byte_cnt == LAST_BYTE) begin
              byte_o  <= '0;
              done_o  <= 1'b1;
              r_state <= IDLE;
            end else begin
              // Zeros shifted in from the bottom become the commit byte after byte 3.
              r_shift    <= r_shift << BYTE_W;
              byte_o     <= r_shift[WORD_W-BYTE_W-1 -: BYTE_W];
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_state    <= SETUP;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptp_b.sv
// Scoreboard bench for ptp_b: two configurations on a shared clock/reset, a
// link-level reference model and a byte-collecting receiver model.
module tb_ptp_b;

  localparam int SC [2] = '{1, 2};
  localparam int HC [2] = '{1, 3};
  localparam int GC [2] = '{1, 1};
  localparam int NB [2] = '{5, 4};

  typedef struct packed {
    logic [7:0] b;
    int         e;
  } rise_t;

  logic        clk;
  logic        reset_i;
  logic [1:0]  load;
  logic [1:0]  ready;
  logic [1:0]  strobe;
  logic [1:0]  done;
  logic [31:0] word [2];
  logic [7:0]  ob   [2];

  int cyc;
  int checks;
  int errors;

  rise_t       rise_q [2][$];
  int          done_q [2][$];
  logic [31:0] word_q [2][$];
  int          acc_e [2];
  int          rdy_e [2];
  int          last_acc [2];

  logic        prev_strobe [2];
  logic [7:0]  prev_byte [2];
  int          last_chg [2];
  int          last_fall [2];
  int          rise_cyc [2];
  logic [31:0] rx_sh [2];
  int          rx_cnt [2];

  ptp_b #(
    .SETUP_CYCLES(1), .HIGH_CYCLES(1), .GAP_CYCLES(1), .COMMIT_EN(1'b1)
  ) dut0 (
    .clk_i(clk), .reset_i(reset_i), .word_i(word[0]), .load_i(load[0]),
    .ready_o(ready[0]), .byte_o(ob[0]), .strobe_o(strobe[0]), .done_o(done[0])
  );

  ptp_b #(
    .SETUP_CYCLES(2), .HIGH_CYCLES(3), .GAP_CYCLES(1), .COMMIT_EN(1'b0)
  ) dut1 (
    .clk_i(clk), .reset_i(reset_i), .word_i(word[1]), .load_i(load[1]),
    .ready_o(ready[1]), .byte_o(ob[1]), .strobe_o(strobe[1]), .done_o(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int per(input int d);
    return SC[d] + HC[d] + GC[d];
  endfunction

  // Reference: byte k of a word strobes at acc + k*P + SETUP; done at acc + N*P.
  task automatic push_model(input int d, input logic [31:0] w);
    int acc;
    logic [7:0] b;
    acc = cyc + 1;
    for (int k = 0; k < NB[d]; k++) begin
      b = (k < 4) ? 8'(w >> (24 - 8 * k)) : 8'h00;
      rise_q[d].push_back('{b: b, e: acc + k * per(d) + SC[d]});
    end
    done_q[d].push_back(acc + NB[d] * per(d));
    word_q[d].push_back(w);
    acc_e[d]    = acc;
    rdy_e[d]    = acc + NB[d] * per(d);
    last_acc[d] = acc;
  endtask

  task automatic send(input int d, input logic [31:0] w);
    int i;
    for (i = 0; i < 200; i++) begin
      if (ready[d]) break;
      @(negedge clk);
    end
    if (i == 200) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d ready_o stayed low for 200 cycles, required high", d);
    end else begin
      load[d] = 1'b1;
      word[d] = w;
      push_model(d, w);
      @(negedge clk);
      load[d] = 1'b0;
      word[d] = $urandom;
    end
  endtask

  task automatic wait_done(input int d);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[d]) break;
    end
    if (i == 200) begin
      checks++; errors++;
      $display("FAIL done_timeout dut%0d done_o never rose within 200 cycles, required a pulse", d);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      rise_q[d].delete();
      done_q[d].delete();
      word_q[d].delete();
      acc_e[d] = 0;
      rdy_e[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset_i) begin
        prev_strobe[d] = 1'b0;
        prev_byte[d]   = 8'h00;
        last_chg[d]    = cyc;
        last_fall[d]   = -100;
        rx_cnt[d]      = 0;
        rx_sh[d]       = '0;
      end else begin
        chk($sformatf("ready_o_dut%0d", d), 32'(ready[d]),
            32'(!((cyc >= acc_e[d]) && (cyc < rdy_e[d]))));
        if (done_q[d].size() > 0 && done_q[d][0] == cyc) begin
          chk($sformatf("done_o_dut%0d", d), 32'(done[d]), 32'd1);
          void'(done_q[d].pop_front());
        end else begin
          chk($sformatf("done_o_dut%0d", d), 32'(done[d]), 32'd0);
        end
        if (ob[d] != prev_byte[d]) begin
          chk($sformatf("byte_hold_high_dut%0d", d), 32'(prev_strobe[d]), 32'd0);
          chk($sformatf("byte_hold_gap_dut%0d", d), 32'(cyc - last_fall[d] >= GC[d]), 32'd1);
          last_chg[d] = cyc;
        end
        if (strobe[d] && !prev_strobe[d]) begin
          chk($sformatf("rise_expected_dut%0d", d), 32'(rise_q[d].size() > 0), 32'd1);
          if (rise_q[d].size() > 0) begin
            rise_t r;
            r = rise_q[d].pop_front();
            chk($sformatf("rise_byte_dut%0d", d), 32'(ob[d]), 32'(r.b));
            chk($sformatf("rise_cycle_dut%0d", d), 32'(cyc), 32'(r.e));
          end
          chk($sformatf("setup_time_dut%0d", d), 32'(cyc - last_chg[d] >= SC[d]), 32'd1);
          if (rx_cnt[d] < 4) rx_sh[d] = {rx_sh[d][23:0], ob[d]};
          rx_cnt[d]++;
          if (rx_cnt[d] == NB[d]) begin
            chk($sformatf("rx_word_avail_dut%0d", d), 32'(word_q[d].size() > 0), 32'd1);
            if (word_q[d].size() > 0)
              chk($sformatf("rx_word_dut%0d", d), rx_sh[d], word_q[d].pop_front());
            rx_cnt[d] = 0;
          end
          rise_cyc[d] = cyc;
        end
        if (!strobe[d] && prev_strobe[d]) begin
          chk($sformatf("high_width_dut%0d", d), 32'(cyc - rise_cyc[d]), 32'(HC[d]));
          last_fall[d] = cyc;
        end
        while (rise_q[d].size() > 0 && rise_q[d][0].e < cyc) begin
          chk($sformatf("rise_missing_dut%0d", d), 32'(cyc), 32'(rise_q[d][0].e));
          void'(rise_q[d].pop_front());
        end
        prev_strobe[d] = strobe[d];
        prev_byte[d]   = ob[d];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded 1 ms, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_i = 1'b1;
    load    = '0;
    word[0] = '0;
    word[1] = '0;
    clear_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_byte_dut%0d", d),   32'(ob[d]),     32'd0);
      chk($sformatf("reset_strobe_dut%0d", d), 32'(strobe[d]), 32'd0);
      chk($sformatf("reset_done_dut%0d", d),   32'(done[d]),   32'd0);
      chk($sformatf("reset_ready_dut%0d", d),  32'(ready[d]),  32'd1);
    end
    repeat (2) @(negedge clk);
    #1 reset_i = 1'b0;

    fork
      begin
        send(0, 32'hDEADBEEF);
        repeat (4) @(negedge clk);
        load[0] = 1'b1;
        word[0] = 32'hBAD0BAD0;
        repeat (3) @(negedge clk);
        load[0] = 1'b0;
        wait_done(0);
        send(0, 32'h01234567);
        wait_done(0);
        send(0, 32'h00000000);
        wait_done(0);
      end
      begin
        send(1, 32'hA5A55A5A);
        wait_done(1);
      end
    join
    repeat (3) @(negedge clk);

    // Reset during HIGH of byte 2, then release with load_i already high.
    send(0, 32'h12345678);
    for (int i = 0; i < 100 && cyc != last_acc[0] + 2 * per(0) + SC[0]; i++) @(negedge clk);
    chk("strobe_before_reset", 32'(strobe[0]), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    chk("async_reset_strobe", 32'(strobe[0]), 32'd0);
    chk("async_reset_byte",   32'(ob[0]),     32'd0);
    chk("async_reset_ready",  32'(ready[0]),  32'd1);
    chk("async_reset_done",   32'(done[0]),   32'd0);
    clear_model();
    @(negedge clk);
    load[0] = 1'b1;
    word[0] = 32'hCAFEF00D;
    #1 reset_i = 1'b0;
    push_model(0, 32'hCAFEF00D);
    @(negedge clk);
    load[0] = 1'b0;
    word[0] = 32'h0;
    wait_done(0);

    fork
      begin
        for (int n = 0; n < 100; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(0, $urandom);
        end
      end
      begin
        for (int n = 0; n < 100; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(1, $urandom);
        end
      end
    join
    repeat (40) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rise_q_drained_dut%0d", d), 32'(rise_q[d].size()), 32'd0);
      chk($sformatf("done_q_drained_dut%0d", d), 32'(done_q[d].size()), 32'd0);
      chk($sformatf("word_q_drained_dut%0d", d), 32'(word_q[d].size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
